// File: rtl/id_alloc_arb.sv
// id_alloc_arb: shared tag pool with round-robin grant, per-requester limits and dual-port release.
module id_alloc_arb #(
  parameter int N_REQ = 4,
  parameter int NUM_ID = 16,
  parameter int ID_W = $clog2(NUM_ID),
  parameter int MAX_OUTST = 8,
  parameter int REQ_W = $clog2(N_REQ),
  parameter int OC_W = $clog2(MAX_OUTST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [ID_W-1:0]         gnt_id,
  input  logic [1:0]              rel_vld,
  input  logic [2*ID_W-1:0]       rel_id,
  output logic                    err_dbl_free,
  output logic [ID_W-1:0]         err_id,
  output logic [ID_W:0]           free_cnt,
  output logic [N_REQ*OC_W-1:0]   outst_cnt
);
  logic [ID_W-1:0] fl [NUM_ID];
  logic [REQ_W-1:0] owner [NUM_ID];
  logic [OC_W-1:0] oc [N_REQ];
  logic [NUM_ID-1:0] in_use;
  logic [ID_W-1:0] head, tail, r0, r1;
  logic [REQ_W-1:0] rr, gi;
  logic [N_REQ-1:0] elig;
  logic gv, g, l0, l1, e0, e1;
  assign r0 = rel_id[ID_W-1:0];
  assign r1 = rel_id[2*ID_W-1:ID_W];
  assign l0 = rel_vld[0] & in_use[r0];
  // a duplicate of port 0's tag on port 1 is rejected even if port 0 itself was illegal
  assign l1 = rel_vld[1] & in_use[r1] & ~(rel_vld[0] & (r1 == r0));
  assign e0 = rel_vld[0] & ~l0;
  assign e1 = rel_vld[1] & ~l1;
  assign gnt_id = fl[head];
  assign g = |req_rdy;
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign elig[i] = req_vld[i] & (oc[i] < OC_W'(MAX_OUTST));
    assign outst_cnt[i*OC_W +: OC_W] = oc[i];
  end
  always_comb begin
    gv = 1'b0;
    gi = rr;
    for (int k = 1; k <= N_REQ; k++)
      if (!gv && free_cnt != '0 && elig[REQ_W'((int'(rr) + k) % N_REQ)]) begin
        gv = 1'b1;
        gi = REQ_W'((int'(rr) + k) % N_REQ);
      end
    req_rdy = (gv && !rst) ? N_REQ'(1) << gi : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ID; i++) begin
        fl[i] <= ID_W'(i);
        owner[i] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) oc[i] <= '0;
      in_use <= '0;
      head <= '0;
      tail <= '0;
      free_cnt <= (ID_W+1)'(NUM_ID);
      rr <= REQ_W'(N_REQ - 1);
      err_dbl_free <= 1'b0;
      err_id <= '0;
    end else begin
      if (g) begin
        in_use[gnt_id] <= 1'b1;
        owner[gnt_id] <= gi;
        rr <= gi;
      end
      if (l0) begin
        fl[tail] <= r0;
        in_use[r0] <= 1'b0;
      end
      if (l1) begin
        fl[tail + ID_W'(l0)] <= r1;
        in_use[r1] <= 1'b0;
      end
      for (int i = 0; i < N_REQ; i++)
        oc[i] <= oc[i] + OC_W'(g && gi == REQ_W'(i)) - OC_W'(l0 && owner[r0] == REQ_W'(i))
                 - OC_W'(l1 && owner[r1] == REQ_W'(i));
      head <= head + ID_W'(g);
      tail <= tail + ID_W'(l0) + ID_W'(l1);
      free_cnt <= free_cnt + (ID_W+1)'(l0) + (ID_W+1)'(l1) - (ID_W+1)'(g);
      err_dbl_free <= e0 | e1;
      err_id <= e0 ? r0 : e1 ? r1 : err_id;
    end
  end
endmodule

// File: tb/tb_id_alloc_arb.sv
// tb_id_alloc_arb: scoreboard bench against a queue-based model of the tag pool.
module tb_id_alloc_arb;
  logic clk = 0, rst = 1;
  logic [3:0] req_vld = '0, req_rdy, gnt_id, err_id;
  logic [1:0] rel_vld = '0;
  logic [7:0] rel_id = '0;
  logic err_dbl_free;
  logic [4:0] free_cnt;
  logic [15:0] outst_cnt;
  id_alloc_arb dut (.clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .gnt_id(gnt_id),
    .rel_vld(rel_vld), .rel_id(rel_id), .err_dbl_free(err_dbl_free), .err_id(err_id),
    .free_cnt(free_cnt), .outst_cnt(outst_cnt));
  always #5 clk = ~clk;
  typedef struct {logic [3:0] rdy; logic [3:0] gid; logic [4:0] fc; logic [15:0] oc; logic err; logic [3:0] eid;} exp_t;
  exp_t sbq[$];
  exp_t me;
  int fq[$];
  int own[16];
  int cnt[4];
  int last, meid, ncmp = 0, nbad = 0;
  bit merr;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("req_rdy", 32'(req_rdy), 32'(me.rdy));
      if (me.rdy != 0) chk("gnt_id", 32'(gnt_id), 32'(me.gid));
      chk("free_cnt", 32'(free_cnt), 32'(me.fc));
      chk("outst_cnt", 32'(outst_cnt), 32'(me.oc));
      chk("err_dbl_free", 32'(err_dbl_free), 32'(me.err));
      if (me.err) chk("err_id", 32'(err_id), 32'(me.eid));
    end
  function automatic exp_t snap(logic [3:0] rdy, int gid);
    exp_t e;
    e.rdy = rdy;
    e.gid = 4'(gid);
    e.fc = 5'(fq.size());
    for (int i = 0; i < 4; i++) e.oc[i*4 +: 4] = 4'(cnt[i]);
    e.err = merr;
    e.eid = 4'(meid);
    return e;
  endfunction
  task automatic mreset();
    fq.delete();
    for (int i = 0; i < 16; i++) begin
      fq.push_back(i);
      own[i] = -1;
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    last = 3;
    merr = 0;
    meid = 0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    req_vld = 4'hF;
    rel_vld = 0;
    mreset();
    sbq.push_back(snap(4'h0, 0));
  endtask
  task automatic step(input logic [3:0] v, input logic [1:0] rv, input int a, input int b);
    int gi, gid;
    bit l0, l1;
    @(posedge clk); #1;
    rst = 0;
    req_vld = v;
    rel_vld = rv;
    rel_id = {4'(b), 4'(a)};
    gi = -1;
    gid = 0;
    if (fq.size() > 0)
      for (int k = 1; k <= 4; k++)
        if (gi < 0 && v[(last + k) % 4] && cnt[(last + k) % 4] < 8) gi = (last + k) % 4;
    if (gi >= 0) gid = fq[0];
    sbq.push_back(snap(gi >= 0 ? 4'(1 << gi) : 4'h0, gid));
    l0 = rv[0] && own[a] >= 0;
    l1 = rv[1] && own[b] >= 0 && !(rv[0] && a == b);
    merr = (rv[0] && !l0) || (rv[1] && !l1);
    if (rv[0] && !l0) meid = a;
    else if (rv[1] && !l1) meid = b;
    if (l0) begin
      cnt[own[a]]--;
      own[a] = -1;
      fq.push_back(a);
    end
    if (l1) begin
      cnt[own[b]]--;
      own[b] = -1;
      fq.push_back(b);
    end
    if (gi >= 0) begin
      void'(fq.pop_front());
      own[gid] = gi;
      cnt[gi]++;
      last = gi;
    end
  endtask
  initial begin
    do_reset();
    repeat (4) step(4'hF, 0, 0, 0);
    step(0, 3, 0, 1);
    step(0, 3, 2, 3);
    do_reset();
    repeat (9) step(4'h4, 0, 0, 0);
    step(4'h4, 1, 0, 0);
    step(4'h4, 0, 0, 0);
    step(4'h4, 0, 0, 0);
    do_reset();
    repeat (17) step(4'hF, 0, 0, 0);
    step(4'hF, 3, 5, 9);
    repeat (3) step(4'hF, 0, 0, 0);
    step(0, 3, 3, 3);
    step(0, 0, 0, 0);
    do_reset();
    repeat (4) step(4'hF, 0, 0, 0);
    step(0, 3, 2, 7);
    step(0, 0, 0, 0);
    step(4'h1, 1, 0, 0);
    do_reset();
    repeat (10) step(4'hF, 0, 0, 0);
    do_reset();
    step(4'hF, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 15);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(4'($urandom), 2'($urandom), a, b);
    end
    step(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
